alu_decode_stage: RTL and testbench
===================================

ALU_DECODE_STAGE -- requirements
Module: alu_decode_stage

Parameters
REQ-001 SHALL have parameter WIDTH, default 32, the width of the immediate output (the instruction is always 32 bits).

Interface
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port in_valid, input, 1 bit: instr is valid this cycle.
REQ-005 SHALL have port in_ready, output, 1 bit: the stage can accept instr this cycle.
REQ-006 SHALL have port instr, input, 32 bits: an RV32I instruction word.
REQ-007 SHALL have port out_valid, output, 1 bit: the decoded bundle is valid.
REQ-008 SHALL have port out_ready, input, 1 bit: the consumer accepts the bundle this cycle.
REQ-009 SHALL have port alu_ctrl, output, 4 bits: ALU operation code for the execute-stage ALU.
REQ-010 SHALL have port imm, output, WIDTH bits: sign-extended immediate.
REQ-011 SHALL have port src_b_imm, output, 1 bit: ALU operand b comes from imm (1) or rs2 (0).
REQ-012 SHALL have port illegal, output, 1 bit: the opcode or funct combination is unsupported.

Function
REQ-013 SHALL encode alu_ctrl as: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLL 0101, SRL 0110, SRA 0111, SLT 1000, SLTU 1001.
REQ-014 SHALL decode OP (0110011) from funct3/funct7; funct7=0100000 is valid only with funct3 000 (SUB) or 101 (SRA); src_b_imm=0.
REQ-015 SHALL decode OP-IMM (0010011) from funct3 with src_b_imm=1; funct3 101 with instr[30]=1 gives SRA; SLLI requires funct7=0000000 and SRLI/SRAI require funct7 0000000 or 0100000, otherwise illegal.
REQ-016 SHALL decode branches (1100011) with src_b_imm=0: BEQ/BNE -> SUB, BLT/BGE -> SLT, BLTU/BGEU -> SLTU; funct3 010 and 011 are illegal.
REQ-017 SHALL give LOAD, STORE, JAL, JALR, LUI and AUIPC alu_ctrl=ADD with src_b_imm=1.
REQ-018 SHALL generate imm in the I/S/B/U/J format selected by the opcode, sign-extended from instr[31] to WIDTH; OP gives imm=0.
REQ-019 SHALL, for any other opcode, drive illegal=1, alu_ctrl=0000, src_b_imm=0 and imm=0; illegal bundles SHALL still be passed through the handshake.
REQ-020 SHALL accept an input transfer when in_valid and in_ready are both 1, and complete an output transfer when out_valid and out_ready are both 1.
REQ-021 SHALL register all outputs, so that latency is 1 cycle from input transfer to out_valid when the output register is empty or draining.
REQ-022 SHALL use a main output register plus one skid register, sustaining 1 transfer per cycle under a continuous out_ready=1.
REQ-023 SHALL drive in_ready = NOT skid_valid, taken from a register with no combinational path from out_ready.
REQ-024 SHALL load the skid register when an input transfer occurs while the output register holds an unaccepted bundle; in_ready then falls on the next cycle.
REQ-025 SHALL, on an output transfer with skid_valid=1, move the skid register into the output register and clear skid_valid in the same edge, and SHALL accept no new input that cycle.
REQ-026 SHALL, on an output transfer and an input transfer in the same cycle with the skid register empty, load the new bundle directly into the output register with out_valid held at 1.
REQ-027 SHALL preserve bundle order, and SHALL never drop or duplicate a bundle.
REQ-028 SHALL hold the output bundle stable while out_valid=1 and out_ready=0.

Reset
REQ-029 SHALL, while reset=1 at a clock edge, clear out_valid, skid_valid, alu_ctrl, imm, src_b_imm and illegal to 0, and set in_ready to 1 from the next cycle.
REQ-030 SHALL, on reset asserted mid-stream, discard any bundles held in the stage and ignore input transfers during that cycle.

Verification
REQ-031 Bench SHALL cover: instr 0x40A485B3 (sub x11,x9,x10), out_ready=1 -> one cycle later out_valid=1, alu_ctrl=0001, src_b_imm=0, illegal=0.
REQ-032 Bench SHALL cover: instr 0xFFF00093 (addi x1,x0,-1) -> alu_ctrl=0000, imm=0xFFFFFFFF, src_b_imm=1.
REQ-033 Bench SHALL cover: instr 0x40335293 (srai x5,x6,3) -> alu_ctrl=0111, imm=0x00000403, src_b_imm=1.
REQ-034 Bench SHALL cover: instr 0x00000000 -> illegal=1, alu_ctrl=0000, out_valid=1.
REQ-035 Bench SHALL cover backpressure: out_ready=0, then two instructions A and B sent back to back -> in_ready=0 after B is accepted; with out_ready=1, A then B appear on consecutive cycles and in_ready returns to 1.
REQ-036 Bench SHALL cover: reset pulsed while both registers are full -> next cycle out_valid=0, in_ready=1, and no stale bundle appears afterwards.

Source files
------------

// File: rtl/alu_decode_stage.sv
// RV32I decode stage: turns an instruction word into ALU control, immediate and
// operand-select bits, behind a valid/ready output register plus one skid entry.
module alu_decode_stage #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      instr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [3:0]       alu_ctrl,
   output logic [WIDTH-1:0] imm,
   output logic             src_b_imm,
   output logic             illegal
);

   typedef struct packed {
      logic             illegal;
      logic             src_b_imm;
      logic [3:0]       alu_ctrl;
      logic [WIDTH-1:0] imm;
   } bundle_t;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_AND  = 4'b0010;
   localparam logic [3:0] ALU_OR   = 4'b0011;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_SLL  = 4'b0101;
   localparam logic [3:0] ALU_SRL  = 4'b0110;
   localparam logic [3:0] ALU_SRA  = 4'b0111;
   localparam logic [3:0] ALU_SLT  = 4'b1000;
   localparam logic [3:0] ALU_SLTU = 4'b1001;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   function automatic logic [WIDTH-1:0] sext32(input logic signed [31:0] v);
      return WIDTH'(v);
   endfunction

   function automatic logic [3:0] base_op(input logic [2:0] f3);
      logic [3:0] op;
      case (f3)
         3'b000:  op = ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = ALU_SRL;
         3'b110:  op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

   function automatic bundle_t decode(input logic [31:0] w);
      bundle_t            b;
      logic               bad;
      logic [2:0]         f3;
      logic [6:0]         f7;
      logic signed [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
      b     = '0;
      bad   = 1'b0;
      f3    = w[14:12];
      f7    = w[31:25];
      imm_i = {{20{w[31]}}, w[31:20]};
      imm_s = {{20{w[31]}}, w[31:25], w[11:7]};
      imm_b = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      imm_u = {w[31:12], 12'b0};
      imm_j = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      case (w[6:0])
         OPC_OP: begin
            b.alu_ctrl = base_op(f3);
            if (f7 == F7_ALT && f3 == 3'b000) b.alu_ctrl = ALU_SUB;
            if (f7 == F7_ALT && f3 == 3'b101) b.alu_ctrl = ALU_SRA;
            bad = !(f7 == F7_BASE || (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101)));
         end
         OPC_OPIMM: begin
            b.src_b_imm = 1'b1;
            b.imm       = sext32(imm_i);
            b.alu_ctrl  = base_op(f3);
            // Shift-immediates reuse the funct7 field; only the canonical patterns are legal.
            if (f3 == 3'b001) bad = (f7 != F7_BASE);
            if (f3 == 3'b101) begin
               if (w[30]) b.alu_ctrl = ALU_SRA;
               bad = !(f7 == F7_BASE || f7 == F7_ALT);
            end
         end
         OPC_BRANCH: begin
            b.imm = sext32(imm_b);
            case (f3)
               3'b000, 3'b001: b.alu_ctrl = ALU_SUB;
               3'b100, 3'b101: b.alu_ctrl = ALU_SLT;
               3'b110, 3'b111: b.alu_ctrl = ALU_SLTU;
               default:        bad = 1'b1;
            endcase
         end
         OPC_LOAD, OPC_JALR: begin
            b.src_b_imm = 1'b1;
            b.imm       = sext32(imm_i);
         end
         OPC_STORE: begin
            b.src_b_imm = 1'b1;
            b.imm       = sext32(imm_s);
         end
         OPC_LUI, OPC_AUIPC: begin
            b.src_b_imm = 1'b1;
            b.imm       = sext32(imm_u);
         end
         OPC_JAL: begin
            b.src_b_imm = 1'b1;
            b.imm       = sext32(imm_j);
         end
         default: bad = 1'b1;
      endcase
      if (bad) begin
         b         = '0;
         b.illegal = 1'b1;
      end
      return b;
   endfunction

   bundle_t dec;
   bundle_t out_q, out_d, skid_q, skid_d;
   logic    out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
   logic    in_fire, out_fire;

   assign dec      = decode(instr);
   assign in_ready = ~skid_valid_q;
   assign in_fire  = in_valid & ~skid_valid_q;
   assign out_fire = out_valid_q & out_ready;

   always_comb begin
      out_d        = out_q;
      out_valid_d  = out_valid_q;
      skid_d       = skid_q;
      skid_valid_d = skid_valid_q;
      if (out_fire && skid_valid_q) begin
         out_d        = skid_q;
         skid_valid_d = 1'b0;
      end else if (out_fire || !out_valid_q) begin
         out_valid_d = in_fire;
         if (in_fire) out_d = dec;
      end else if (in_fire) begin
         // Output is stalled: park the new bundle so in_ready can stay registered.
         skid_d       = dec;
         skid_valid_d = 1'b1;
      end
   end

   // Output register and skid entry
   always_ff @(posedge clk) begin
      if (reset) begin
         out_q        <= '0;
         out_valid_q  <= 1'b0;
         skid_q       <= '0;
         skid_valid_q <= 1'b0;
      end else begin
         out_q        <= out_d;
         out_valid_q  <= out_valid_d;
         skid_q       <= skid_d;
         skid_valid_q <= skid_valid_d;
      end
   end

   assign out_valid = out_valid_q;
   assign alu_ctrl  = out_q.alu_ctrl;
   assign imm       = out_q.imm;
   assign src_b_imm = out_q.src_b_imm;
   assign illegal   = out_q.illegal;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Bench for alu_decode_stage: directed cases plus random traffic checked against
// an in-order queue model and a table-driven RV32I decode reference.
module tb_alu_decode_stage;
   localparam int WIDTH = 32;

   logic             clk = 1'b0;
   logic             reset, in_valid, out_ready;
   logic [31:0]      instr;
   logic             in_ready, out_valid, src_b_imm, illegal;
   logic [3:0]       alu_ctrl;
   logic [WIDTH-1:0] imm;

   typedef struct {
      logic        ill;
      logic        srcb;
      logic [3:0]  ctrl;
      logic [31:0] imm;
   } exp_t;

   logic [31:0] q[$];
   int          checks = 0;
   int          errors = 0;
   // ALU code indexed by funct3 for the base (funct7 = 0) register/immediate ops
   logic [3:0]  op_tab[8] = '{4'h0, 4'h5, 4'h8, 4'h9, 4'h4, 4'h6, 4'h3, 4'h2};

   alu_decode_stage #(.WIDTH(WIDTH)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .instr(instr), .out_valid(out_valid), .out_ready(out_ready),
      .alu_ctrl(alu_ctrl), .imm(imm), .src_b_imm(src_b_imm), .illegal(illegal)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] sx(input logic [31:0] v, input int bits);
      logic signed [31:0] t;
      t = v << (32 - bits);
      return t >>> (32 - bits);
   endfunction

   function automatic exp_t ref_decode(input logic [31:0] w);
      exp_t       e;
      bit         ok;
      logic [2:0] f3;
      logic [6:0] f7;
      e.ill = 1'b0; e.srcb = 1'b0; e.ctrl = 4'h0; e.imm = 32'h0;
      ok = 1'b1;
      f3 = w[14:12];
      f7 = w[31:25];
      case (w[6:0])
         7'h33: begin
            if (f7 == 7'h00)                    e.ctrl = op_tab[f3];
            else if (f7 == 7'h20 && f3 == 3'd0) e.ctrl = 4'h1;
            else if (f7 == 7'h20 && f3 == 3'd5) e.ctrl = 4'h7;
            else                                ok = 1'b0;
         end
         7'h13: begin
            e.srcb = 1'b1;
            e.imm  = sx({20'h0, w[31:20]}, 12);
            if (f3 == 3'd1 && f7 != 7'h00)      ok = 1'b0;
            else if (f3 == 3'd5 && f7 == 7'h20) e.ctrl = 4'h7;
            else if (f3 == 3'd5 && f7 != 7'h00) ok = 1'b0;
            else                                e.ctrl = op_tab[f3];
         end
         7'h63: begin
            e.imm = sx((32'(w[31]) << 12) | (32'(w[7]) << 11) | (32'(w[30:25]) << 5)
                       | (32'(w[11:8]) << 1), 13);
            if (f3 == 3'd0 || f3 == 3'd1)      e.ctrl = 4'h1;
            else if (f3 == 3'd4 || f3 == 3'd5) e.ctrl = 4'h8;
            else if (f3 == 3'd6 || f3 == 3'd7) e.ctrl = 4'h9;
            else                               ok = 1'b0;
         end
         7'h03, 7'h67: begin e.srcb = 1'b1; e.imm = sx({20'h0, w[31:20]}, 12); end
         7'h23: begin e.srcb = 1'b1; e.imm = sx((32'(w[31:25]) << 5) | 32'(w[11:7]), 12); end
         7'h37, 7'h17: begin e.srcb = 1'b1; e.imm = 32'(w[31:12]) * 4096; end
         7'h6f: begin
            e.srcb = 1'b1;
            e.imm  = sx((32'(w[31]) << 20) | (32'(w[19:12]) << 12) | (32'(w[20]) << 11)
                        | (32'(w[30:21]) << 1), 21);
         end
         default: ok = 1'b0;
      endcase
      if (!ok) begin
         e.ill = 1'b1; e.srcb = 1'b0; e.ctrl = 4'h0; e.imm = 32'h0;
      end
      return e;
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] w;
      w = $urandom;
      case ($urandom_range(0, 10))
         0: w[6:0] = 7'h33;  1: w[6:0] = 7'h13;  2: w[6:0] = 7'h63;
         3: w[6:0] = 7'h03;  4: w[6:0] = 7'h23;  5: w[6:0] = 7'h6f;
         6: w[6:0] = 7'h67;  7: w[6:0] = 7'h37;  8: w[6:0] = 7'h17;
         9: w[6:0] = 7'h33;  default: ;
      endcase
      case ($urandom_range(0, 3))
         0: w[31:25] = 7'h00;
         1: w[31:25] = 7'h20;
         default: ;
      endcase
      return w;
   endfunction

   // One clock: drive at negedge, advance the queue model at posedge, compare at negedge.
   task automatic cycle(input logic v, input logic [31:0] ins, input logic ordy, input logic rst);
      bit   in_fire, out_fire;
      exp_t e;
      in_valid  = v;
      instr     = ins;
      out_ready = ordy;
      reset     = rst;
      in_fire   = v && (q.size() < 2);
      out_fire  = (q.size() > 0) && ordy;
      @(posedge clk);
      if (rst) q.delete();
      else begin
         if (out_fire) void'(q.pop_front());
         if (in_fire) q.push_back(ins);
      end
      @(negedge clk);
      check("out_valid", 64'(out_valid), 64'(q.size() > 0));
      check("in_ready", 64'(in_ready), 64'(q.size() < 2));
      if (q.size() > 0) begin
         e = ref_decode(q[0]);
         check("alu_ctrl", 64'(alu_ctrl), 64'(e.ctrl));
         check("imm", 64'(imm), 64'(e.imm));
         check("src_b_imm", 64'(src_b_imm), 64'(e.srcb));
         check("illegal", 64'(illegal), 64'(e.ill));
      end
   endtask

   initial begin
      logic [31:0] ia, ib;
      ia = 32'h00A50533;   // add x10,x10,x10
      ib = 32'h0FF57513;   // andi x10,x10,255
      reset = 1'b1; in_valid = 1'b0; instr = 32'h0; out_ready = 1'b0;
      @(negedge clk);
      cycle(1'b0, 32'h0, 1'b0, 1'b1);
      cycle(1'b0, 32'h0, 1'b0, 1'b1);
      check("rst_alu_ctrl", 64'(alu_ctrl), 64'h0);
      check("rst_imm", 64'(imm), 64'h0);
      check("rst_src_b_imm", 64'(src_b_imm), 64'h0);
      check("rst_illegal", 64'(illegal), 64'h0);

      cycle(1'b1, 32'h40A485B3, 1'b1, 1'b0);
      check("sub_valid", 64'(out_valid), 64'h1);
      check("sub_ctrl", 64'(alu_ctrl), 64'h1);
      check("sub_srcb", 64'(src_b_imm), 64'h0);
      check("sub_ill", 64'(illegal), 64'h0);
      cycle(1'b1, 32'hFFF00093, 1'b1, 1'b0);
      check("addi_ctrl", 64'(alu_ctrl), 64'h0);
      check("addi_imm", 64'(imm), 64'hFFFFFFFF);
      check("addi_srcb", 64'(src_b_imm), 64'h1);
      cycle(1'b1, 32'h40335293, 1'b1, 1'b0);
      check("srai_ctrl", 64'(alu_ctrl), 64'h7);
      check("srai_imm", 64'(imm), 64'h403);
      check("srai_srcb", 64'(src_b_imm), 64'h1);
      cycle(1'b1, 32'h00000000, 1'b1, 1'b0);
      check("zero_ill", 64'(illegal), 64'h1);
      check("zero_ctrl", 64'(alu_ctrl), 64'h0);
      check("zero_valid", 64'(out_valid), 64'h1);
      cycle(1'b0, 32'h0, 1'b1, 1'b0);

      cycle(1'b1, ia, 1'b0, 1'b0);
      cycle(1'b1, ib, 1'b0, 1'b0);
      check("bp_in_ready", 64'(in_ready), 64'h0);
      check("bp_a_ctrl", 64'(alu_ctrl), 64'h0);
      cycle(1'b0, 32'h0, 1'b1, 1'b0);
      check("bp_b_valid", 64'(out_valid), 64'h1);
      check("bp_b_ctrl", 64'(alu_ctrl), 64'h2);
      check("bp_ready_back", 64'(in_ready), 64'h1);
      cycle(1'b0, 32'h0, 1'b1, 1'b0);
      check("bp_drained", 64'(out_valid), 64'h0);

      cycle(1'b1, ia, 1'b0, 1'b0);
      cycle(1'b1, ib, 1'b0, 1'b0);
      cycle(1'b1, 32'h40A485B3, 1'b1, 1'b1);
      check("mid_rst_valid", 64'(out_valid), 64'h0);
      check("mid_rst_ready", 64'(in_ready), 64'h1);
      check("mid_rst_ctrl", 64'(alu_ctrl), 64'h0);
      cycle(1'b0, 32'h0, 1'b1, 1'b0);
      cycle(1'b0, 32'h0, 1'b1, 1'b0);
      check("no_stale", 64'(out_valid), 64'h0);

      for (int i = 0; i < 40; i++) cycle(1'b1, rand_instr(), 1'b1, 1'b0);
      for (int i = 0; i < 1500; i++)
         cycle($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 2) != 0,
               $urandom_range(0, 63) == 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
